call_scheduler: RTL and testbench
=================================

# call_scheduler

- Upstream stage of the elevator controller.
- Captures asynchronous floor call buttons into a pending-request register and chooses the next target floor using a direction-preserving (SCAN) policy.
- Drives `req_floor` into the comparator/FSM path.
- Clears a request when the car opens its door at that floor.

## Interface

Parameters:
- `IDLE_CYCLES`, default 1000: idle clocks before homing to floor 0. Used only with `IDLE_HOME_EN`. Legal range 2 to 2^16−1.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset. Assertion immediately forces all state to reset values; release is sampled on `clk`.
- `call_btn`  input  4  one bit per floor 0–3. Asynchronous and level-held by the user; only the rising edge is used.
- `curr_floor`  input  2  current car floor from the floor counter.
- `door_open`  input  1  door-open indication from the FSM.
- `req_floor`  output  2  registered target floor for the comparator.
- `req_valid`  output  1  registered; high while any request is pending.
- `pending`  output  4  registered pending-request bitmap.
- `dir_up`  output  1  registered; high when the scheduler is in `SERVE_UP`.

## Operation

Button capture:
- Each `call_btn` bit passes through a 2-flop synchronizer, then a rising-edge detector (previous-value flop).
- A detected edge sets `pending[i]`.
- A held button sets its bit once only.

Pending clear:
- `pending[curr_floor]` clears on every cycle that `door_open`=1.
- If a clear and a set hit the same bit in the same cycle, the clear wins: the press is dropped because the door is already open there.

State machine, with states `IDLE`, `SERVE_UP` and `SERVE_DOWN`. The transitions below are evaluated on the pending value after the set and clear updates of that cycle.
- `IDLE`:
  - Stays in `IDLE` if `pending`=0.
  - Moves to `SERVE_UP` if any pending floor is greater than `curr_floor`.
  - Otherwise moves to `SERVE_DOWN` if any pending floor is less than `curr_floor`.
  - Otherwise (only `curr_floor` pending) stays in `IDLE` with target `curr_floor`.
- `SERVE_UP`:
  - Target is the lowest pending floor ≥ `curr_floor`.
  - If there is none, moves to `SERVE_DOWN` when any floor is pending, else to `IDLE`.
- `SERVE_DOWN`:
  - Target is the highest pending floor ≤ `curr_floor`.
  - If there is none, moves to `SERVE_UP` when any floor is pending, else to `IDLE`.

Target and output behaviour:
- A newly pending floor that lies between the car and its current target, in the direction of travel, replaces the target on the next cycle.
- `req_floor` updates only while `pending`≠0. When nothing is pending it holds its last value.
- `req_valid` = (`pending`≠0), registered.
- All floor comparisons are 2-bit unsigned. No wrap-around: floor 3 has nothing above it and floor 0 has nothing below it.

## Timing

Reset values:
- `pending`=0000, `req_floor`=0, `req_valid`=0, `dir_up`=0.
- State = `IDLE`; synchronizer and edge flops = 0; idle counter = 0.

Latency:
- Button rising edge sampled at clock edge k → `pending[i]` set at edge k+2.
- `req_floor`, `req_valid` and `dir_up` reflect that change at edge k+3.
- `door_open` high at edge m → pending bit clears at edge m; `req_floor` and state advance at edge m+1.

Reset mid-operation:
- All pending requests are discarded.
- A button still held across reset release does not register, because the edge flops reset to 0 and the synchronizer refills first. The user must release and press again.

## Configuration

Macro: `CALL_SCHED_IDLE_HOME_EN`.

Defined:
- A 16-bit counter increments each cycle while state=`IDLE`, `pending`=0, `door_open`=0 and `curr_floor`≠0.
- The counter clears when any of those conditions is false.
- When it reaches `IDLE_CYCLES`−1 it sets `pending[0]` on the next edge and clears itself. This is the same effect as a call at floor 0.

Undefined:
- No counter logic is present.
- The car stays at its last floor indefinitely while idle.

## Test plan

- Reset with `call_btn`=0100 held, then release reset → `pending` stays 0000 and `req_valid`=0. Release and re-press the button → `pending`=0100 two edges later, and one edge after that `req_floor`=2, `dir_up`=1.
- Car at floor 0, press floors 3 then 1 → after the floor-1 press, `req_floor` changes from 3 to 1. `door_open` at floor 1 clears bit 1 and `req_floor` returns to 3.
- Car at floor 2 in `SERVE_UP` with floors 3 and 0 pending → target 3. After bit 3 clears, state = `SERVE_DOWN` and `req_floor`=0.
- Press floor 1 while car is at floor 1 with `door_open`=1 in the same clearing cycle → `pending[1]` stays 0.
- Assert `reset` low while floors 0 and 3 are pending → outputs go to reset values immediately, without waiting for `clk`.
- With `CALL_SCHED_IDLE_HOME_EN` defined and `IDLE_CYCLES`=8: car at floor 2, idle with door closed → `pending`=0001 after 8 cycles, then `req_floor`=0, `dir_up`=0. Undefined: `pending` stays 0000 for 100+ cycles.

Source files
------------

// File: rtl/call_scheduler_if.sv
// call_scheduler_if: call buttons and car status in, scheduled target floor and pending bitmap out.
interface call_scheduler_if;
   logic [3:0] call_btn;
   logic [1:0] curr_floor;
   logic       door_open;
   logic [1:0] req_floor;
   logic       req_valid;
   logic [3:0] pending;
   logic       dir_up;
   modport master (output call_btn, curr_floor, door_open, input req_floor, req_valid, pending, dir_up);
   modport slave (input call_btn, curr_floor, door_open, output req_floor, req_valid, pending, dir_up);
endinterface

// File: rtl/call_scheduler.sv
// call_scheduler: latches floor calls and picks the next target floor with a direction-preserving SCAN policy.
// Idle homing to floor 0 after IDLE_CYCLES clocks is built only when CALL_SCHED_IDLE_HOME_EN is defined.
module call_scheduler #(
   parameter int IDLE_CYCLES = 1000
) (
   input logic             clk,
   input logic             reset,
   call_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SERVE_UP, SERVE_DOWN} state_t;
   state_t     state_q;
   logic [3:0] sync1_q, sync2_q, prev_q, pending_q, pending_d, set_v, clr_v;
   logic [2:0] prime_q;
   logic [1:0] req_floor_q, ge_floor, le_floor;
   logic       req_valid_q, dir_up_q, ge_found, le_found, up_any, dn_any, go_up, home;

   if (IDLE_CYCLES < 2 || IDLE_CYCLES > 65535) begin : g_bad_idle_cycles
      $error("IDLE_CYCLES out of range");
   end

   always_comb begin
      ge_found = 1'b0;
      le_found = 1'b0;
      ge_floor = bus.curr_floor;
      le_floor = bus.curr_floor;
      up_any   = 1'b0;
      dn_any   = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (pending_q[i] && 2'(i) >= bus.curr_floor) begin
            ge_found = 1'b1;
            ge_floor = 2'(i);
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (pending_q[i] && 2'(i) <= bus.curr_floor) begin
            le_found = 1'b1;
            le_floor = 2'(i);
         end
         up_any = up_any | (pending_q[i] && 2'(i) > bus.curr_floor);
         dn_any = dn_any | (pending_q[i] && 2'(i) < bus.curr_floor);
      end
   end

   // Edges are ignored until the synchronizer holds post-reset samples, so a button held through reset is dropped.
   assign set_v     = (sync2_q & ~prev_q & {4{prime_q[2]}}) | {3'b000, home};
   assign clr_v     = bus.door_open ? 4'b0001 << bus.curr_floor : 4'b0000;
   assign pending_d = (pending_q | set_v) & ~clr_v;
   assign go_up     = (state_q == IDLE) ? up_any : (state_q == SERVE_UP) ? ge_found : !le_found;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         prime_q   <= '0;
         pending_q <= '0;
      end else begin
         sync1_q   <= bus.call_btn;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         prime_q   <= {prime_q[1:0], 1'b1};
         pending_q <= pending_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         req_floor_q <= '0;
         req_valid_q <= 1'b0;
         dir_up_q    <= 1'b0;
      end else begin
         req_valid_q <= |pending_q;
         dir_up_q    <= 1'b0;
         if (pending_q == 4'b0000) begin
            state_q <= IDLE;
         end else if (go_up) begin
            state_q     <= SERVE_UP;
            req_floor_q <= ge_floor;
            dir_up_q    <= 1'b1;
         end else if (state_q != IDLE || dn_any) begin
            state_q     <= SERVE_DOWN;
            req_floor_q <= le_floor;
         end else begin
            state_q     <= IDLE;
            req_floor_q <= bus.curr_floor;
         end
      end
   end

`ifdef CALL_SCHED_IDLE_HOME_EN
   logic [15:0] idle_cnt_q;
   logic        idle_ok;
   assign idle_ok = state_q == IDLE && pending_q == 4'b0000 && !bus.door_open && bus.curr_floor != 2'd0;
   assign home    = idle_ok && idle_cnt_q == 16'(IDLE_CYCLES - 1);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) idle_cnt_q <= '0;
      else        idle_cnt_q <= (idle_ok && !home) ? idle_cnt_q + 16'd1 : 16'd0;
   end
`else
   assign home = 1'b0;
`endif

   assign bus.req_floor = req_floor_q;
   assign bus.req_valid = req_valid_q;
   assign bus.pending   = pending_q;
   assign bus.dir_up    = dir_up_q;
endmodule

// File: tb/tb_call_scheduler.sv
// tb_call_scheduler: vector table plus hand sequences for reset, clear-wins and idle homing, checked via a scoreboard queue.
module tb_call_scheduler;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      string      name;
      logic [3:0] p;
      logic [1:0] rf;
      logic       v;
      logic       u;
   } exp_t;

   typedef struct {
      logic [3:0] btn;
      logic [1:0] cf;
      logic       d;
      int         n;
      logic [3:0] p;
      logic [1:0] rf;
      logic       v;
      logic       u;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];

   call_scheduler_if bus();
   call_scheduler #(.IDLE_CYCLES(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] b, input logic [1:0] c, input logic d);
      bus.call_btn   = b;
      bus.curr_floor = c;
      bus.door_open  = d;
   endtask

   task automatic expect_out(input string name, input logic [3:0] p, input logic [1:0] rf, input logic v, input logic u);
      exp_t e;
      e.name = name;
      e.p    = p;
      e.rf   = rf;
      e.v    = v;
      e.u    = u;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: no expectation queued");
         return;
      end
      e = sb.pop_front();
      if ({bus.pending, bus.req_floor, bus.req_valid, bus.dir_up} !== {e.p, e.rf, e.v, e.u}) begin
         errors++;
         $display("FAIL %s: got pending=%b req_floor=%0d req_valid=%b dir_up=%b, want pending=%b req_floor=%0d req_valid=%b dir_up=%b",
                  e.name, bus.pending, bus.req_floor, bus.req_valid, bus.dir_up, e.p, e.rf, e.v, e.u);
      end
   endtask

   task automatic row(input logic [3:0] b, input logic [1:0] c, input logic d, input int n,
                      input logic [3:0] p, input logic [1:0] rf, input logic v, input logic u);
      vec_t r;
      r.btn = b; r.cf = c; r.d = d; r.n = n;
      r.p = p; r.rf = rf; r.v = v; r.u = u;
      tbl.push_back(r);
   endtask

   initial begin
      // Car at 0: floor 3 then floor 1 pressed; floor 1 lies on the way and takes over the target.
      row(4'b1000, 2'd0, 1'b0, 4, 4'b1000, 2'd3, 1'b1, 1'b1);
      row(4'b0000, 2'd0, 1'b0, 2, 4'b1000, 2'd3, 1'b1, 1'b1);
      row(4'b0010, 2'd0, 1'b0, 4, 4'b1010, 2'd1, 1'b1, 1'b1);
      row(4'b0000, 2'd1, 1'b0, 2, 4'b1010, 2'd1, 1'b1, 1'b1);
      row(4'b0000, 2'd1, 1'b1, 1, 4'b1000, 2'd1, 1'b1, 1'b1);
      row(4'b0000, 2'd1, 1'b0, 1, 4'b1000, 2'd3, 1'b1, 1'b1);
      // Car at 2 serving up with 3 and 0 pending, then reversal after floor 3 clears.
      row(4'b0000, 2'd2, 1'b0, 2, 4'b1000, 2'd3, 1'b1, 1'b1);
      row(4'b0001, 2'd2, 1'b0, 4, 4'b1001, 2'd3, 1'b1, 1'b1);
      row(4'b0000, 2'd3, 1'b1, 1, 4'b0001, 2'd3, 1'b1, 1'b1);
      row(4'b0000, 2'd3, 1'b0, 1, 4'b0001, 2'd0, 1'b1, 1'b0);
      row(4'b0000, 2'd0, 1'b1, 1, 4'b0000, 2'd0, 1'b1, 1'b0);
      row(4'b0000, 2'd0, 1'b0, 1, 4'b0000, 2'd0, 1'b0, 1'b0);
      // Press at the open-door floor is dropped; holding the button does not re-register it.
      row(4'b0010, 2'd1, 1'b1, 4, 4'b0000, 2'd0, 1'b0, 1'b0);
      row(4'b0010, 2'd0, 1'b0, 3, 4'b0000, 2'd0, 1'b0, 1'b0);
      row(4'b0000, 2'd0, 1'b0, 2, 4'b0000, 2'd0, 1'b0, 1'b0);
      // Only the current floor pending: stay idle targeting it.
      row(4'b0010, 2'd1, 1'b0, 4, 4'b0010, 2'd1, 1'b1, 1'b0);
      row(4'b0000, 2'd1, 1'b1, 1, 4'b0000, 2'd1, 1'b1, 1'b0);
      row(4'b0000, 2'd1, 1'b0, 1, 4'b0000, 2'd1, 1'b0, 1'b0);
      // Car at 3 (nothing above): serve down, a lower floor appearing on the way replaces the target.
      row(4'b0100, 2'd3, 1'b0, 4, 4'b0100, 2'd2, 1'b1, 1'b0);
      row(4'b0000, 2'd3, 1'b0, 1, 4'b0100, 2'd2, 1'b1, 1'b0);
      row(4'b0001, 2'd3, 1'b0, 4, 4'b0101, 2'd2, 1'b1, 1'b0);
      row(4'b0000, 2'd2, 1'b1, 1, 4'b0001, 2'd2, 1'b1, 1'b0);
      row(4'b0000, 2'd2, 1'b0, 1, 4'b0001, 2'd0, 1'b1, 1'b0);
      row(4'b0010, 2'd2, 1'b0, 4, 4'b0011, 2'd1, 1'b1, 1'b0);
      row(4'b0000, 2'd1, 1'b1, 1, 4'b0001, 2'd1, 1'b1, 1'b0);
      row(4'b0000, 2'd0, 1'b1, 1, 4'b0000, 2'd0, 1'b1, 1'b0);
      row(4'b0000, 2'd0, 1'b0, 1, 4'b0000, 2'd0, 1'b0, 1'b0);
      row(4'b1001, 2'd1, 1'b0, 4, 4'b1001, 2'd3, 1'b1, 1'b1);

      drive(4'b0100, 2'd0, 1'b0);
      step();
      step();
      expect_out("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
      check_out();
      reset = 1'b1;
      repeat (5) step();
      expect_out("held_across_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      check_out();
      drive(4'b0000, 2'd0, 1'b0);
      step();
      step();
      drive(4'b0100, 2'd0, 1'b0);
      expect_out("repress_pending", 4'b0100, 2'd0, 1'b0, 1'b0);
      repeat (3) step();
      check_out();
      expect_out("repress_target", 4'b0100, 2'd2, 1'b1, 1'b1);
      step();
      check_out();
      drive(4'b0000, 2'd2, 1'b1);
      step();
      drive(4'b0000, 2'd2, 1'b0);
      expect_out("idle_holds_req_floor", 4'b0000, 2'd2, 1'b0, 1'b0);
      step();
      check_out();

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].btn, tbl[i].cf, tbl[i].d);
         expect_out($sformatf("vec%0d", i), tbl[i].p, tbl[i].rf, tbl[i].v, tbl[i].u);
         repeat (tbl[i].n) step();
         check_out();
      end

      #3 reset = 1'b0;
      #1 expect_out("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      check_out();
      drive(4'b0000, 2'd0, 1'b0);
      step();
      reset = 1'b1;
      step();
      drive(4'b0000, 2'd2, 1'b0);
      expect_out("idle_before_home", 4'b0000, 2'd0, 1'b0, 1'b0);
      repeat (7) step();
      check_out();
`ifdef CALL_SCHED_IDLE_HOME_EN
      expect_out("home_pending", 4'b0001, 2'd0, 1'b0, 1'b0);
      step();
      check_out();
      expect_out("home_target", 4'b0001, 2'd0, 1'b1, 1'b0);
      step();
      check_out();
`else
      expect_out("no_homing", 4'b0000, 2'd0, 1'b0, 1'b0);
      repeat (113) step();
      check_out();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
